melody_sequencer: RTL and testbench
===================================

# melody_sequencer

Parametrised melody playback engine for the sound output path. It steps through a song ROM whose entries each carry a note index and a duration, looks up the tone frequency, and generates a phase-aligned square wave. The square wave is mapped to a 7-bit duty cycle that feeds the existing PWM serializer. Over a fixed looping note table it adds per-note durations, rests, start/stop control, a one-shot or loop mode, and a done pulse.

## Interface
- SYS_FREQ_HZ, 100_000_000, system clock frequency in Hz
- TICK_HZ, 8, duration tick rate; TICK_CYCLES = SYS_FREQ_HZ/TICK_HZ
- SONG_LEN, 9, number of song entries (1..32)
- NUM_FREQS, 17, frequency table depth
- FREQ_W, 11, frequency table entry width (Hz)
- SONG_FILE, "flappy_bird_notes.mem", song ROM image; entry = {dur[3:0], note[4:0]}
- FREQ_FILE, "FREQs.mem", frequency ROM image
- DUTY_HI, 75, duty when tone high; DUTY_LO, 25, duty when tone low; DUTY_MID, 50, duty when silent

- clk  in  1  system clock; single clock domain
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  begin playback from entry 0 (sampled in IDLE only)
- stop  in  1  abort playback
- loop_en  in  1  1 = wrap to entry 0 after last entry; 0 = one-shot
- busy  out  1  high in LOAD and PLAY
- done  out  1  one-cycle pulse at natural end of a one-shot song
- note_addr  out  5  index of the current song entry
- tone  out  1  square wave at the current note frequency
- duty_cycle  out  7  value for the PWM serializer

## Operation
- States: IDLE, LOAD, PLAY.
- IDLE:
  - busy=0, tone=0, duty_cycle=DUTY_MID, note_addr=0.
  - start=1 and stop=0 -> LOAD.
- LOAD (exactly one cycle):
  - Register entry SONG[note_addr].
  - Register half-period limit HP = SYS_FREQ_HZ/(2*freq) - 1 (32-bit unsigned).
  - Clear tone counter, tick counter, tone, and duration counter.
  - -> PLAY.
- PLAY:
  - The note lasts (dur+1)*TICK_CYCLES cycles; dur=0 gives 1 tick, dur=15 gives 16 ticks.
  - Tone counter: if count < HP, increment; else clear and toggle tone. The first toggle is HP+1 cycles after PLAY entry.
  - Rest: note=5'h1F, or note>=NUM_FREQS, or freq=0. Tone is held 0 and duty_cycle=DUTY_MID. No divide occurs with freq=0.
  - Non-rest: duty_cycle = tone ? DUTY_HI : DUTY_LO, updated in the same cycle as tone.
  - On the final cycle of the note:
    - note_addr < SONG_LEN-1: increment note_addr -> LOAD.
    - note_addr = SONG_LEN-1 and loop_en=1: note_addr=0 -> LOAD.
    - note_addr = SONG_LEN-1 and loop_en=0: -> IDLE with done=1 for that one cycle.
- loop_en is sampled only at the last-entry boundary; changing it mid-song has no other effect.
- stop=1 in LOAD or PLAY: -> IDLE on the next edge. No done pulse; outputs take their IDLE values.
- start while busy: ignored.
- start and stop in the same cycle: stop wins, so the block stays in or returns to IDLE.
- Reset asserted mid-operation: immediate IDLE, all outputs at their reset values, counters 0.
- Reset values: busy=0, done=0, note_addr=0, tone=0, duty_cycle=DUTY_MID.

## Timing
- start sampled high at edge N -> busy=1 after edge N (LOAD) -> PLAY after edge N+1.
- Per-note period = 1 LOAD cycle + (dur+1)*TICK_CYCLES PLAY cycles.
- One-shot song length = sum over entries of (1 + (dur+1)*TICK_CYCLES) cycles. done is asserted in the cycle after the final PLAY cycle, coinciding with busy=0.
- HP is computed from the ROM value in LOAD. A registered divide with up to 1 cycle of extra latency is allowed only if it is hidden within LOAD.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
Simulation parameters: SYS_FREQ_HZ=1000, TICK_HZ=100 (TICK_CYCLES=10), SONG_LEN=3. FREQ[1]=100 gives HP=4.

- Reset/idle: hold reset, then release with start=0 -> busy=0, done=0, duty_cycle=50, tone=0 for 50 cycles.
- Single note: entry0={dur=1, note=1}, others rests dur=0, loop_en=0, pulse start:
  - tone toggles every 5 cycles for 20 cycles; duty alternates 25/75.
  - note_addr steps 0,1,2.
  - done pulses once after 1+20+1+10+1+10 = 43 cycles from LOAD entry; busy falls with done.
- Loop: same song with loop_en=1 -> note_addr wraps 2->0 with no done pulse. Drop loop_en during entry 1 -> song ends after entry 2 with done=1.
- Stop mid-note: stop 7 cycles into entry 0 -> IDLE next cycle, duty_cycle=50, no done. A later start replays from entry 0 with tone phase reset.
- Boundaries: start+stop in the same cycle -> stays IDLE. start during PLAY -> ignored. note=5'h1F and note=20 -> duty_cycle=50 for the full duration.
- Async reset mid-PLAY, asserted between clock edges -> busy=0, tone=0 immediately; after release, IDLE.

Source files
------------

// File: rtl/melody_sequencer_if.sv
// Control and status bundle between the melody sequencer and its controller.
// The controller drives start/stop/loop_en; the sequencer returns status and audio.
interface melody_sequencer_if;
   logic       start;
   logic       stop;
   logic       loop_en;
   logic       busy;
   logic       done;
   logic [4:0] note_addr;
   logic       tone;
   logic [6:0] duty_cycle;

   modport master (
      output start, stop, loop_en,
      input  busy, done, note_addr, tone, duty_cycle
   );

   modport slave (
      input  start, stop, loop_en,
      output busy, done, note_addr, tone, duty_cycle
   );
endinterface

// File: rtl/melody_sequencer.sv
// Song ROM playback engine: per-entry note/duration, square-wave tone generation
// and a 25/50/75 duty mapping for the downstream PWM serializer.
module melody_sequencer #(
   parameter int unsigned SYS_FREQ_HZ = 100_000_000,
   parameter int unsigned TICK_HZ     = 8,
   parameter int unsigned SONG_LEN    = 9,
   parameter int unsigned NUM_FREQS   = 17,
   parameter int unsigned FREQ_W      = 11,
   // Song image, entry 0 in the least significant bits; entry = {dur[3:0], note[4:0]}
   parameter logic [SONG_LEN*9-1:0] SONG_DATA = {
      9'h0F1, 9'h03F, 9'h034, 9'h036, 9'h018, 9'h01F, 9'h016, 9'h035, 9'h038},
   parameter logic [NUM_FREQS*FREQ_W-1:0] FREQ_DATA = {
      11'd1175, 11'd1047, 11'd988, 11'd880, 11'd784, 11'd698, 11'd659, 11'd587,
      11'd523,  11'd494,  11'd440, 11'd392, 11'd349, 11'd330, 11'd294, 11'd262, 11'd0},
   parameter int unsigned DUTY_HI     = 75,
   parameter int unsigned DUTY_LO     = 25,
   parameter int unsigned DUTY_MID    = 50
) (
   input  logic               clk,
   input  logic               reset,
   melody_sequencer_if.slave  bus
);

   localparam int unsigned TICK_CYCLES = SYS_FREQ_HZ / TICK_HZ;
   localparam logic [31:0] TICK_LAST   = 32'(TICK_CYCLES - 1);
   localparam logic [4:0]  LAST_ADDR   = 5'(SONG_LEN - 1);
   localparam logic [6:0]  D_HI        = 7'(DUTY_HI);
   localparam logic [6:0]  D_LO        = 7'(DUTY_LO);
   localparam logic [6:0]  D_MID       = 7'(DUTY_MID);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PLAY} state_t;

   state_t              state, state_nxt;
   logic [8:0]          rom_entry;
   logic [FREQ_W-1:0]   rom_freq;
   logic                rom_rest;
   logic [31:0]         rom_hp;
   logic [3:0]          dur;
   logic                rest;
   logic [31:0]         hp;
   logic [31:0]         tone_cnt;
   logic [31:0]         tick_cnt;
   logic [3:0]          dur_cnt;
   logic                note_end;
   logic                last_entry;

   function automatic logic [FREQ_W-1:0] freq_of(input logic [4:0] n);
      if (32'(n) < NUM_FREQS) return FREQ_DATA[32'(n)*FREQ_W +: FREQ_W];
      return '0;
   endfunction

   // Divisor is forced non-zero so a silent entry never divides by zero.
   function automatic logic [31:0] half_period(input logic [FREQ_W-1:0] f);
      logic [31:0] divisor;
      divisor = (f == '0) ? 32'd2 : (32'(f) << 1);
      return 32'(SYS_FREQ_HZ) / divisor - 32'd1;
   endfunction

   always_comb begin
      rom_entry  = SONG_DATA[32'(bus.note_addr)*9 +: 9];
      rom_freq   = freq_of(rom_entry[4:0]);
      rom_rest   = (rom_entry[4:0] == 5'h1F) || (32'(rom_entry[4:0]) >= NUM_FREQS) ||
                   (rom_freq == '0);
      rom_hp     = half_period(rom_freq);
      note_end   = (tick_cnt == TICK_LAST) && (dur_cnt == dur);
      last_entry = (bus.note_addr == LAST_ADDR);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (bus.start && !bus.stop) state_nxt = S_LOAD;
         S_LOAD: state_nxt = bus.stop ? S_IDLE : S_PLAY;
         S_PLAY: begin
            if (bus.stop)                              state_nxt = S_IDLE;
            else if (note_end && last_entry && !bus.loop_en) state_nxt = S_IDLE;
            else if (note_end)                         state_nxt = S_LOAD;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bus.busy       <= 1'b0;
         bus.done       <= 1'b0;
         bus.note_addr  <= '0;
         bus.tone       <= 1'b0;
         bus.duty_cycle <= D_MID;
         dur            <= '0;
         rest           <= 1'b1;
         hp             <= '0;
         tone_cnt       <= '0;
         tick_cnt       <= '0;
         dur_cnt        <= '0;
      end else begin
         bus.busy <= (state_nxt != S_IDLE);
         bus.done <= 1'b0;
         if (state == S_IDLE || bus.stop) begin
            bus.note_addr  <= '0;
            bus.tone       <= 1'b0;
            bus.duty_cycle <= D_MID;
            tone_cnt       <= '0;
            tick_cnt       <= '0;
            dur_cnt        <= '0;
         end else if (state == S_LOAD) begin
            dur            <= rom_entry[8:5];
            rest           <= rom_rest;
            hp             <= rom_hp;
            tone_cnt       <= '0;
            tick_cnt       <= '0;
            dur_cnt        <= '0;
            bus.tone       <= 1'b0;
            bus.duty_cycle <= rom_rest ? D_MID : D_LO;
         end else if (note_end) begin
            // Entry boundary: silence for the LOAD cycle, then advance or finish.
            bus.tone       <= 1'b0;
            bus.duty_cycle <= D_MID;
            if (!last_entry) bus.note_addr <= bus.note_addr + 5'd1;
            else             bus.note_addr <= '0;
            if (last_entry && !bus.loop_en) bus.done <= 1'b1;
         end else begin
            if (tick_cnt == TICK_LAST) begin
               tick_cnt <= '0;
               dur_cnt  <= dur_cnt + 4'd1;
            end else begin
               tick_cnt <= tick_cnt + 32'd1;
            end
            if (tone_cnt < hp) begin
               tone_cnt <= tone_cnt + 32'd1;
            end else begin
               tone_cnt <= '0;
               if (!rest) begin
                  bus.tone       <= ~bus.tone;
                  bus.duty_cycle <= bus.tone ? D_LO : D_HI;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_melody_sequencer.sv
// Randomized bench for melody_sequencer against a segment-timeline reference model.
module tb_melody_sequencer;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   melody_sequencer_if bus();

   localparam logic [17*11-1:0] FREQ_TB = {
      11'd1600, 11'd1500, 11'd1400, 11'd1300, 11'd1200, 11'd1100, 11'd1000, 11'd900,
      11'd800,  11'd700,  11'd600,  11'd500,  11'd400,  11'd300,  11'd200,  11'd100, 11'd0};

   melody_sequencer #(
      .SYS_FREQ_HZ(1000), .TICK_HZ(100), .SONG_LEN(3), .NUM_FREQS(17), .FREQ_W(11),
      .SONG_DATA({9'h014, 9'h01F, 9'h021}), .FREQ_DATA(FREQ_TB),
      .DUTY_HI(75), .DUTY_LO(25), .DUTY_MID(50)
   ) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   // Reference song, same content as the image above
   int song_dur  [3] = '{1, 0, 0};
   int song_note [3] = '{1, 31, 20};

   int n_checks = 0;
   int n_errors = 0;

   // Model: playing flag, current entry, cycles elapsed since that entry's LOAD cycle
   bit m_active = 0;
   int m_entry  = 0;
   int m_t      = 0;
   bit m_done   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int freq_hz(input int n);
      return (n >= 0 && n < 17) ? 100 * n : 0;
   endfunction

   function automatic bit is_rest(input int e);
      int n = song_note[e];
      return (n == 31) || (n >= 17) || (freq_hz(n) == 0);
   endfunction

   function automatic int play_len(input int e);
      return (song_dur[e] + 1) * 10;
   endfunction

   task automatic model_step();
      m_done = 0;
      if (!m_active) begin
         if (bus.start && !bus.stop) begin
            m_active = 1; m_entry = 0; m_t = 0;
         end
      end else if (bus.stop) begin
         m_active = 0; m_entry = 0;
      end else begin
         m_t++;
         if (m_t == 1 + play_len(m_entry)) begin
            m_t = 0;
            if (m_entry < 2)       m_entry++;
            else if (bus.loop_en)  m_entry = 0;
            else begin m_active = 0; m_entry = 0; m_done = 1; end
         end
      end
   endtask

   task automatic compare_all();
      int exp_tone, exp_duty, k, hp;
      exp_tone = 0;
      exp_duty = 50;
      if (m_active && m_t > 0 && !is_rest(m_entry)) begin
         k        = m_t - 1;
         hp       = 1000 / (2 * freq_hz(song_note[m_entry])) - 1;
         exp_tone = (k / (hp + 1)) % 2;
         exp_duty = exp_tone ? 75 : 25;
      end
      check("busy", bus.busy, m_active);
      check("done", bus.done, m_done);
      check("note_addr", bus.note_addr, m_active ? m_entry : 0);
      check("tone", bus.tone, exp_tone);
      check("duty_cycle", bus.duty_cycle, exp_duty);
   endtask

   task automatic step(input logic s, input logic p);
      bus.start = s;
      bus.stop  = p;
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare_all();
   endtask

   initial begin
      int first_done, dones, found;
      bus.start = 0; bus.stop = 0; bus.loop_en = 0;

      // Reset and idle
      repeat (3) begin @(negedge clk); compare_all(); end
      reset = 0;
      repeat (50) step(0, 0);

      // One-shot playback with latency measurement
      step(1, 0);
      first_done = 0; dones = 0;
      for (int i = 1; i <= 60; i++) begin
         step(0, 0);
         if (bus.done === 1'b1) begin
            dones++;
            if (first_done == 0) first_done = i;
         end
      end
      check("done_latency", first_done, 43);
      check("done_count_oneshot", dones, 1);

      // Looping, then drop loop_en during entry 1
      bus.loop_en = 1;
      step(1, 0);
      dones = 0;
      repeat (100) begin step(0, 0); if (bus.done === 1'b1) dones++; end
      check("done_count_loop", dones, 0);
      found = 0;
      for (int i = 0; i < 50 && !found; i++) begin
         step(0, 0);
         if (bus.note_addr == 5'd1) found = 1;
      end
      check("wait_entry1", found, 1);
      repeat ($urandom_range(0, 8)) step(0, 0);
      bus.loop_en = 0;
      dones = 0;
      repeat (40) begin step(0, 0); if (bus.done === 1'b1) dones++; end
      check("done_count_loop_exit", dones, 1);
      check("idle_after_loop_exit", bus.busy, 0);

      // Stop mid-note, then replay from entry 0
      step(1, 0);
      repeat ($urandom_range(3, 18)) step(0, 0);
      step(0, 1);
      repeat (5) step(0, 0);
      step(1, 0);
      repeat (25) step(0, 0);

      // start during PLAY is ignored; start with stop stays idle
      repeat (4) step(1, 0);
      repeat (30) step(0, 0);
      step(1, 1);
      step(0, 0);

      // Random control traffic
      repeat (1500) begin
         if ($urandom_range(0, 29) == 0) bus.loop_en = ~bus.loop_en;
         step($urandom_range(0, 19) == 0, $urandom_range(0, 59) == 0);
      end

      // Asynchronous reset in the middle of a note
      bus.loop_en = 0;
      step(0, 1);
      step(1, 0);
      repeat (7) step(0, 0);
      #2 reset = 1;
      #1;
      m_active = 0; m_entry = 0; m_t = 0; m_done = 0;
      check("async_rst_busy", bus.busy, 0);
      check("async_rst_tone", bus.tone, 0);
      check("async_rst_duty", bus.duty_cycle, 50);
      check("async_rst_addr", bus.note_addr, 0);
      repeat (2) @(negedge clk);
      reset = 0;
      repeat (10) step(0, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
